// File: rtl/conv_pkg.sv
// Shared definitions for the convolution feeder: FSM state type and the
// default pixel width.
package conv_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/conv_pos_counter.sv
// Raster position tracker for a PW x PH padded frame.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   adv_i       step to the next raster position
//   col_o/row_o current position
//   wrap_o      current column is the last of its row
//   last_o      current position is the final one of the frame
module conv_pos_counter #(
  parameter int unsigned PW = 10,
  parameter int unsigned PH = 10,
  localparam int unsigned CW = (PW > 1) ? $clog2(PW) : 1,
  localparam int unsigned RW = (PH > 1) ? $clog2(PH) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          adv_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          wrap_o,
  output logic          last_o
);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign wrap_o = (col_q == CW'(PW - 1));
  assign last_o = wrap_o && (row_q == RW'(PH - 1));

  // Column wraps into the next row; the final position returns to origin.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (adv_i) begin
      if (wrap_o) begin
        col_d = '0;
        row_d = last_o ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/conv_feeder.sv
// Streams one raster frame into a convolution line buffer, inserting a
// zero border of PAD pixels on every side when CONV_FEEDER_PAD_EN is
// defined (otherwise the frame passes through unpadded and PAD is unused).
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   start                one-cycle frame request (honoured in IDLE only)
//   in_data/in_valid     raster-order source pixels
//   in_ready             combinational: an interior pixel is taken this cycle
//   out_data/out_valid   registered padded pixel stream
//   out_sol/out_last     registered column-0 / final-pixel markers
//   busy                 state is RUN
//   done                 state is DONE, one cycle after out_last
module conv_feeder
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned IMG_W      = 8,
  parameter int unsigned IMG_H      = 8,
  parameter int unsigned PAD        = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_sol,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

`ifdef CONV_FEEDER_PAD_EN
  localparam int unsigned PAD_E = PAD;
`else
  localparam int unsigned PAD_E = PAD - PAD;
`endif
  localparam int unsigned PW = IMG_W + 2 * PAD_E;
  localparam int unsigned PH = IMG_H + 2 * PAD_E;
  localparam int unsigned CW = (PW > 1) ? $clog2(PW) : 1;
  localparam int unsigned RW = (PH > 1) ? $clog2(PH) : 1;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_sol_q, out_sol_d;
  logic                  out_last_q, out_last_d;

  logic          adv;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          wrap;
  logic          last;
  logic          border;
  logic          unused_wrap;

  conv_pos_counter #(
    .PW(PW),
    .PH(PH)
  ) u_pos (
    .clk   (clk),
    .rstn  (rstn),
    .adv_i (adv),
    .col_o (col),
    .row_o (row),
    .wrap_o(wrap),
    .last_o(last)
  );

  assign unused_wrap = wrap;

`ifdef CONV_FEEDER_PAD_EN
  assign border = (int'(row) < int'(PAD_E)) || (int'(row) >= int'(PAD_E + IMG_H)) ||
                  (int'(col) < int'(PAD_E)) || (int'(col) >= int'(PAD_E + IMG_W));
`else
  assign border = 1'b0;
`endif

  // Next state, position advance and next output word. The RUN cycle in
  // which out_last is visible is a drain cycle: the counters have already
  // wrapped to the origin, so nothing is accepted or emitted before DONE.
  always_comb begin
    state_d     = state_q;
    adv         = 1'b0;
    in_ready    = 1'b0;
    out_data_d  = '0;
    out_valid_d = 1'b0;
    out_sol_d   = 1'b0;
    out_last_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (out_last_q) begin
          state_d = DONE;
        end else begin
          in_ready = !border;
          adv      = border || in_valid;
          if (adv) begin
            out_valid_d = 1'b1;
            out_data_d  = border ? '0 : in_data;
            out_sol_d   = (col == '0);
            out_last_d  = last;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sol_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sol_q   <= out_sol_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sol   = out_sol_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_conv_feeder.sv
// Randomized bench for conv_feeder: each frame's expected output is built
// from the padded-frame definition (border -> 0, interior -> next source
// pixel in raster order) and compared beat by beat.
module tb_conv_feeder;

  localparam int DW = 16;
  localparam int IW = 8;
  localparam int IH = 8;
  localparam int PD = 1;
`ifdef CONV_FEEDER_PAD_EN
  localparam int PE = PD;
`else
  localparam int PE = 0;
`endif
  localparam int PW = IW + 2 * PE;
  localparam int PH = IH + 2 * PE;
  localparam int N  = PW * PH;
  localparam int NI = IW * IH;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_sol;
  logic          out_last;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] src[$];
  logic [DW-1:0] exp_q[$];

  conv_feeder #(
    .DATA_WIDTH(DW),
    .IMG_W     (IW),
    .IMG_H     (IH),
    .PAD       (PD)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_sol  (out_sol),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_border(input int p);
    int r;
    int c;
    r = p / PW;
    c = p % PW;
    return (r < PE) || (r >= PE + IH) || (c < PE) || (c >= PE + IW);
  endfunction

  function automatic bit drive_valid(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 2) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data"},  32'(out_data),  32'd0);
    check({tag, "_sol"},   32'(out_sol),   32'd0);
    check({tag, "_last"},  32'(out_last),  32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_done"},  32'(done),      32'd0);
    check({tag, "_ready"}, 32'(in_ready),  32'd0);
  endtask

  // One frame: start pulse, then per-cycle checks until done (or abort).
  task automatic run_frame(input int mode, input int restart_at, input int abort_beat);
    int beats = 0;
    int idx   = 0;
    int dones = 0;
    int cyc   = 0;
    bit run_b = 1'b1;
    bit last_prev = 1'b0;
    bit fin   = 1'b0;
    bit exp_ready;
    int k;

    src.delete();
    exp_q.delete();
    for (int i = 0; i < NI; i++) src.push_back(DW'($urandom));
    k = 0;
    for (int p = 0; p < N; p++) begin
      if (is_border(p)) exp_q.push_back('0);
      else begin
        exp_q.push_back(src[k]);
        k++;
      end
    end

    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = src[0];
    #1 check("ready_idle", 32'(in_ready), 32'd0);

    while (!fin && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (abort_beat >= 0 && beats == abort_beat) begin
        rstn = 1'b0;
        start = 1'b0;
        #1 check_all_zero("abort_rst");
        repeat (2) @(negedge clk);
        check_all_zero("abort_hold");
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("abort_no_done", 32'(done), 32'd0);
          check("abort_no_busy", 32'(busy), 32'd0);
        end
        return;
      end

      if (out_valid) begin
        if (beats < N) begin
          check("data", 32'(out_data), 32'(exp_q[beats]));
          check("sol",  32'(out_sol),  32'(beats % PW == 0));
          check("last", 32'(out_last), 32'(beats == N - 1));
        end else begin
          check("extra_beat", 32'(beats), 32'(N - 1));
        end
        beats++;
      end else begin
        check("idle_data", 32'(out_data), 32'd0);
      end
      check("done", 32'(done), 32'(last_prev));
      check("busy", 32'(busy), 32'(run_b));
      if (done) dones++;
      exp_ready = run_b && !out_last && beats < N && !is_border(beats);
      if (last_prev) fin = 1'b1;
      last_prev = out_last;
      if (out_last) run_b = 1'b0;

      start    = (cyc == restart_at);
      in_valid = drive_valid(mode, cyc);
      in_data  = (idx < NI) ? src[idx] : DW'($urandom);
      #1 check("ready", 32'(in_ready), 32'(exp_ready));
      if (in_ready && in_valid) idx++;
    end
    check("frame_finished", 32'(fin), 32'd1);
    check("beat_count", 32'(beats), 32'(N));
    check("done_count", 32'(dones), 32'd1);
    check("consumed", 32'(idx), 32'(NI));
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    rstn     = 1'b0;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = DW'($urandom);
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    run_frame(0, -1, -1);   // in_valid held high
    run_frame(1, -1, -1);   // in_valid toggling
    run_frame(2, 20, -1);   // random in_valid, stray start mid-frame
    run_frame(2, -1, 40);   // reset at beat 40
    run_frame(0, -1, -1);   // clean frame after the abort

    // Offered data in IDLE must not be taken.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      #1 check("idle_ready", 32'(in_ready), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_feeder.md
CONV_FEEDER -- requirements
Module: conv_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 8, unpadded frame width in pixels.
REQ-003 SHALL have parameter IMG_H, default 8, unpadded frame height in pixels.
REQ-004 SHALL have parameter PAD, default 1, zero-pad border width on every side.
REQ-005 SHALL have port clk, input, 1, single clock, rising edge.
REQ-006 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, one-cycle request to begin a frame.
REQ-008 SHALL have port in_data, input, DATA_WIDTH, raster-order pixel.
REQ-009 SHALL have port in_valid, input, 1, in_data is valid.
REQ-010 SHALL have port in_ready, output, 1, feeder accepts in_data this cycle.
REQ-011 SHALL have port out_data, output, DATA_WIDTH, padded pixel to the downstream shift-register serial_in.
REQ-012 SHALL have port out_valid, output, 1, out_data holds a frame pixel.
REQ-013 SHALL have port out_sol, output, 1, out_data is column 0 of a padded row.
REQ-014 SHALL have port out_last, output, 1, out_data is the final padded pixel.
REQ-015 SHALL have port busy, output, 1, high in state RUN.
REQ-016 SHALL have port done, output, 1, one-cycle pulse after the last pixel.

Function
REQ-017 SHALL emit a padded frame of PW=IMG_W+2*PAD by PH=IMG_H+2*PAD pixels in raster order, tracked by counters col (0..PW-1) and row (0..PH-1).
REQ-018 SHALL implement FSM IDLE -> RUN on start; RUN -> DONE when the last position is emitted; DONE -> IDLE unconditionally after one cycle.
REQ-019 SHALL ignore start outside IDLE.
REQ-020 SHALL treat a position as border when row<PAD, row>=PAD+IMG_H, col<PAD or col>=PAD+IMG_W.
REQ-021 At a border position in RUN: in_ready=0; SHALL emit out_data=0 with out_valid=1 and advance the position.
REQ-022 At an interior position in RUN: in_ready=1 (combinational); if in_valid, SHALL emit in_data with out_valid=1 and advance; otherwise SHALL emit out_valid=0, out_data=0 and hold the position.
REQ-023 out_data, out_valid, out_sol and out_last SHALL be registered, one cycle after the accepting/advancing edge.
REQ-024 Advance: col wraps PW-1 -> 0 and row increments; at row=PH-1 and col=PW-1, counters return to 0.
REQ-025 out_sol SHALL be 1 exactly when the emitted position has col=0; out_last SHALL be 1 exactly for row=PH-1, col=PW-1.
REQ-026 in_ready SHALL be 0 in IDLE and DONE; in_data offered there is not consumed.
REQ-027 done SHALL be 1 only in state DONE, the cycle after out_last.

Reset
REQ-028 On rstn=0, asynchronously: state=IDLE, row=col=0, out_data=0, out_valid=0, out_sol=0, out_last=0, done=0; busy=0, in_ready=0.
REQ-029 Reset mid-frame SHALL abandon the frame with no done pulse; the next start SHALL begin at row 0, col 0.

Configuration
REQ-030 With macro CONV_FEEDER_PAD_EN defined, padding SHALL behave per REQ-017..REQ-025 using PAD.
REQ-031 Without CONV_FEEDER_PAD_EN, the effective pad SHALL be 0: frame is IMG_W x IMG_H, no border positions exist, and the PAD parameter is ignored.

Structure
REQ-032 A shared package conv_pkg SHALL hold the FSM state type (IDLE, RUN, DONE) and the default DATA_WIDTH constant.
REQ-033 The row/col position tracking SHALL be one sub-module, conv_pos_counter, exposing col, row, wrap and last flags.

Verification
REQ-034 Defaults, in_valid held 1, start pulsed: exactly 100 out_valid beats, 36 zeros, interior 0..63 in order, out_last on beat 100, done one cycle later.
REQ-035 in_valid toggling 1/0 each cycle: interior beats delayed, border beats unaffected, output sequence identical to REQ-034, no duplicated or lost pixels.
REQ-036 start pulsed again during RUN: ignored, frame count still 100 beats, single done.
REQ-037 rstn low at beat 40, then start: all outputs 0 during reset, new frame begins with a zero border pixel and out_sol=1, no done from the aborted frame.
REQ-038 CONV_FEEDER_PAD_EN undefined, IMG_W=IMG_H=4: 16 beats equal to input 0..15, in_ready high for every beat, out_sol on beats 1,5,9,13.
